// File: rtl/qedmma_pkg.sv
// Shared QEDMMA datapath types and constants.
// Fixed-point defaults, divider states and saturation helpers.
package qedmma_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int FRAC_BITS       = 16;
  localparam int TARGET_ID_WIDTH = 3;

  typedef logic signed [DATA_WIDTH-1:0] fp_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Bit patterns are returned in 64 bits; callers slice to their width.
  function automatic logic [63:0] fp_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fp_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/qedmma_fp_sat_round.sv
// Quotient post-processing: optional rounding, sign apply,
// saturation and divide-by-zero substitution.
module qedmma_fp_sat_round #(
  parameter int DATA_WIDTH = qedmma_pkg::DATA_WIDTH,
  parameter int Q_WIDTH    = 48,
  parameter bit ROUND_EN   = 1'b0
) (
  input  logic [Q_WIDTH-1:0]    quot_i,
  input  logic                  sign_i,
  input  logic                  dz_i,
  input  logic                  a_zero_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  dz_o,
  output logic                  ovf_o
);
  import qedmma_pkg::*;

  localparam logic [63:0] MAX64 = fp_max(DATA_WIDTH);
  localparam logic [63:0] MIN64 = fp_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] Q_MAX = MAX64[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] Q_MIN = MIN64[DATA_WIDTH-1:0];
  localparam logic [Q_WIDTH-1:0] POS_LIM = Q_WIDTH'(Q_MAX);
  localparam logic [Q_WIDTH-1:0] NEG_LIM = Q_WIDTH'(Q_MIN);

  logic [Q_WIDTH-1:0]    mag;
  logic [DATA_WIDTH-1:0] mag_lo;
  logic [DATA_WIDTH-1:0] neg_lo;
  logic                  ovf;

  always_comb begin
    mag = quot_i;
    if (ROUND_EN) begin
      mag = (quot_i >> 1) + Q_WIDTH'(quot_i[0]);
    end
  end

  assign mag_lo = mag[DATA_WIDTH-1:0];
  assign neg_lo = -mag_lo;

  // Negative side may reach one more LSB than the positive side.
  assign ovf = sign_i ? (mag > NEG_LIM) : (mag > POS_LIM);

  always_comb begin
    q_o   = sign_i ? neg_lo : mag_lo;
    ovf_o = ovf;
    if (ovf) begin
      q_o = sign_i ? Q_MIN : Q_MAX;
    end
    if (dz_i) begin
      ovf_o = 1'b0;
      if (a_zero_i) begin
        q_o = '0;
      end else begin
        q_o = sign_i ? Q_MIN : Q_MAX;
      end
    end
  end

  assign dz_o = dz_i;

endmodule

// File: rtl/qedmma_fp_div_seq.sv
// Sequential signed fixed-point divider, q = (a << FRAC_BITS) / b,
// restoring radix-2 with saturation, sticky flags and handshakes.
module qedmma_fp_div_seq #(
  parameter int DATA_WIDTH = qedmma_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = qedmma_pkg::FRAC_BITS,
  parameter bit ROUND_EN   = 1'b0,
  parameter int TAG_WIDTH  = qedmma_pkg::TARGET_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_dz,
  output logic                  out_ovf,
  output logic                  sticky_dz,
  output logic                  sticky_ovf,
  input  logic                  sticky_clr
);
  import qedmma_pkg::*;

  localparam int R      = ROUND_EN ? 1 : 0;
  localparam int N_ITER = DATA_WIDTH + FRAC_BITS + R;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N_ITER - 1);

  div_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH-1:0] babs_q, babs_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH-1:0] rem_sub;
  logic                  qbit;
  logic [N_ITER-1:0]     num_q, num_d;
  logic [N_ITER-1:0]     quot_q, quot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic                  dz_q, dz_d;
  logic                  az_q, az_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  accept;

  logic [DATA_WIDTH-1:0] fix_q;
  logic                  fix_dz, fix_ovf;

  logic [DATA_WIDTH-1:0] oq_q, oq_d;
  logic [TAG_WIDTH-1:0]  otag_q, otag_d;
  logic                  odz_q, odz_d;
  logic                  oovf_q, oovf_d;
  logic                  ovalid_q, ovalid_d;
  logic                  sdz_q, sdz_d;
  logic                  sovf_q, sovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (in_b == '0) ? FIX : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
  end

  assign accept = in_valid && in_ready;

  // |MIN| wraps to itself, which is correct as an unsigned magnitude.
  assign abs_a = in_a[DATA_WIDTH-1] ? -in_a : in_a;
  assign abs_b = in_b[DATA_WIDTH-1] ? -in_b : in_b;

  assign rem_sh  = {rem_q, num_q[N_ITER-1]};
  assign qbit    = rem_sh >= {1'b0, babs_q};
  assign rem_sub = rem_sh[DATA_WIDTH-1:0] - babs_q;

  always_comb begin
    babs_d = babs_q;
    rem_d  = rem_q;
    num_d  = num_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    dz_d   = dz_q;
    az_d   = az_q;
    tag_d  = tag_q;
    if (state_q == IDLE && accept) begin
      babs_d = abs_b;
      sign_d = in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
      dz_d   = (in_b == '0);
      az_d   = (in_a == '0);
      tag_d  = in_tag;
      num_d  = N_ITER'(abs_a) << (FRAC_BITS + R);
      rem_d  = '0;
      quot_d = '0;
      cnt_d  = CNT_INIT;
    end else if (state_q == CALC) begin
      rem_d  = qbit ? rem_sub : rem_sh[DATA_WIDTH-1:0];
      quot_d = {quot_q[N_ITER-2:0], qbit};
      num_d  = num_q << 1;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      babs_q <= '0;
      rem_q  <= '0;
      num_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      dz_q   <= 1'b0;
      az_q   <= 1'b0;
      tag_q  <= '0;
    end else begin
      babs_q <= babs_d;
      rem_q  <= rem_d;
      num_q  <= num_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      dz_q   <= dz_d;
      az_q   <= az_d;
      tag_q  <= tag_d;
    end
  end

  qedmma_fp_sat_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q_WIDTH    (N_ITER),
    .ROUND_EN   (ROUND_EN)
  ) u_fix (
    .quot_i   (quot_q),
    .sign_i   (sign_q),
    .dz_i     (dz_q),
    .a_zero_i (az_q),
    .q_o      (fix_q),
    .dz_o     (fix_dz),
    .ovf_o    (fix_ovf)
  );

  always_comb begin
    oq_d     = oq_q;
    otag_d   = otag_q;
    odz_d    = odz_q;
    oovf_d   = oovf_q;
    ovalid_d = ovalid_q;
    if (state_q == FIX) begin
      oq_d     = fix_q;
      otag_d   = tag_q;
      odz_d    = fix_dz;
      oovf_d   = fix_ovf;
      ovalid_d = 1'b1;
    end else if (state_q == DONE && out_ready) begin
      ovalid_d = 1'b0;
    end
  end

  // Clear beats a set landing in the same cycle.
  always_comb begin
    sdz_d  = sdz_q | ((state_q == FIX) && fix_dz);
    sovf_d = sovf_q | ((state_q == FIX) && fix_ovf);
    if (sticky_clr) begin
      sdz_d  = 1'b0;
      sovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oq_q     <= '0;
      otag_q   <= '0;
      odz_q    <= 1'b0;
      oovf_q   <= 1'b0;
      ovalid_q <= 1'b0;
      sdz_q    <= 1'b0;
      sovf_q   <= 1'b0;
    end else begin
      oq_q     <= oq_d;
      otag_q   <= otag_d;
      odz_q    <= odz_d;
      oovf_q   <= oovf_d;
      ovalid_q <= ovalid_d;
      sdz_q    <= sdz_d;
      sovf_q   <= sovf_d;
    end
  end

  assign out_valid  = ovalid_q;
  assign out_q      = oq_q;
  assign out_tag    = otag_q;
  assign out_dz     = odz_q;
  assign out_ovf    = oovf_q;
  assign sticky_dz  = sdz_q;
  assign sticky_ovf = sovf_q;

endmodule

// File: tb/tb_qedmma_fp_div_seq.sv
// Bench for qedmma_fp_div_seq: truncating and rounding instances
// checked against an arithmetic reference model.
module tb_qedmma_fp_div_seq;

  localparam int DW = 32;
  localparam int FB = 16;
  localparam int TW = 3;

  typedef struct {
    logic [DW-1:0] q;
    logic          dz;
    logic          ovf;
    logic [TW-1:0] tag;
    int            lat;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_q;
  logic [TW-1:0] out_tag;
  logic          out_dz, out_ovf, sticky_dz, sticky_ovf;
  logic          sticky_clr = 1'b0;

  logic          r_rst = 1'b1;
  logic          r_in_valid = 1'b0;
  logic          r_in_ready;
  logic [DW-1:0] r_in_a = '0;
  logic [DW-1:0] r_in_b = '0;
  logic [TW-1:0] r_in_tag = '0;
  logic          r_out_valid;
  logic [DW-1:0] r_out_q;
  logic [TW-1:0] r_out_tag;
  logic          r_out_dz, r_out_ovf, r_sdz, r_sovf;
  logic          r_done = 1'b0;

  qedmma_fp_div_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROUND_EN(1'b0), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .out_dz(out_dz), .out_ovf(out_ovf),
    .sticky_dz(sticky_dz), .sticky_ovf(sticky_ovf),
    .sticky_clr(sticky_clr)
  );

  qedmma_fp_div_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROUND_EN(1'b1), .TAG_WIDTH(TW)
  ) dut_r (
    .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_a(r_in_a), .in_b(r_in_b), .in_tag(r_in_tag),
    .out_valid(r_out_valid), .out_ready(1'b1), .out_q(r_out_q),
    .out_tag(r_out_tag), .out_dz(r_out_dz), .out_ovf(r_out_ovf),
    .sticky_dz(r_sdz), .sticky_ovf(r_sovf), .sticky_clr(1'b0)
  );

  // Reference: exact integer quotient of magnitudes, then sign/saturate.
  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b,
                                 logic [TW-1:0] tag, bit rnd);
    exp_t e;
    longint sa, sb, ua, ub, num, mag, lim;
    bit neg;
    sa = $signed(a);
    sb = $signed(b);
    e.tag = tag;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (b == '0) begin
      e.dz = 1'b1;
      e.lat = 2;
      e.q = (sa > 0) ? 32'h7FFFFFFF : (sa < 0) ? 32'h80000000 : 32'h0;
    end else begin
      ua = (sa < 0) ? -sa : sa;
      ub = (sb < 0) ? -sb : sb;
      neg = (sa < 0) != (sb < 0);
      num = ua << FB;
      mag = rnd ? (2 * num + ub) / (2 * ub) : num / ub;
      lim = neg ? (64'sd1 <<< (DW - 1)) : (64'sd1 <<< (DW - 1)) - 1;
      if (mag > lim) begin
        e.ovf = 1'b1;
        e.q = neg ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
        e.q = neg ? 32'(-mag) : 32'(mag);
      end
      e.lat = DW + FB + (rnd ? 1 : 0) + 2;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_op();
    int s;
    logic [DW-1:0] v;
    s = $urandom_range(0, 15);
    v = $urandom;
    if (s == 0) return '0;
    if (s == 1) return 32'h80000000;
    if (s == 2) return 32'h00010000;
    return $signed(v) >>> $urandom_range(0, 30);
  endfunction

  exp_t expq[$];
  exp_t ce;
  bit   seen = 0;
  bit   hs_prev = 0;
  bit   post_rst = 0;
  bit   clr_next = 0;
  bit   m_sdz = 0;
  bit   m_sovf = 0;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      seen = 0;
      hs_prev = 0;
      clr_next = 0;
      m_sdz = 0;
      m_sovf = 0;
      post_rst = 1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end else begin
      if (post_rst) begin
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_q", {32'd0, out_q}, 64'd0);
        chk("rst_out_tag", {61'd0, out_tag}, 64'd0);
        chk("rst_idle_ready", {63'd0, in_ready}, 64'd1);
        post_rst = 0;
      end
      if (clr_next) begin
        m_sdz = 0;
        m_sovf = 0;
        clr_next = 0;
      end
      if (hs_prev) begin
        chk("hs_valid_low", {63'd0, out_valid}, 64'd0);
        chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
        hs_prev = 0;
      end
      if (out_valid) begin
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got q=%h required no result",
                   out_q);
        end else begin
          ce = expq[0];
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - ce.acc), 64'(ce.lat));
            m_sdz = m_sdz | ce.dz;
            m_sovf = m_sovf | ce.ovf;
          end
          chk("out_q", {32'd0, out_q}, {32'd0, ce.q});
          chk("out_tag", {61'd0, out_tag}, {61'd0, ce.tag});
          chk("out_dz", {63'd0, out_dz}, {63'd0, ce.dz});
          chk("out_ovf", {63'd0, out_ovf}, {63'd0, ce.ovf});
          if (out_ready) begin
            void'(expq.pop_front());
            seen = 0;
            hs_prev = 1;
          end
        end
      end
      chk("sticky_dz", {63'd0, sticky_dz}, {63'd0, m_sdz});
      chk("sticky_ovf", {63'd0, sticky_ovf}, {63'd0, m_sovf});
      if (sticky_clr) clr_next = 1;
    end
  end

  // 0: always ready, 1: random ready, 2: held low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 :
                (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic do_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] tag);
    exp_t e;
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
      in_valid = 1'b0;
      return;
    end
    e = model(a, b, tag, 1'b0);
    e.acc = cyc;
    expq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_tag = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0",
               expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : round_inst
    exp_t e;
    int n;
    logic [DW-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    r_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = (i == 0) ? 32'h00020000 : (i == 1) ? 32'hFFFE0000 : rnd_op();
      b = (i < 2) ? 32'h00030000 : rnd_op();
      @(posedge clk);
      #1;
      r_in_valid = 1'b1;
      r_in_a = a;
      r_in_b = b;
      r_in_tag = 3'(i);
      n = 0;
      @(negedge clk);
      while (!r_in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      e = model(a, b, 3'(i), 1'b1);
      e.acc = cyc;
      @(posedge clk);
      #1;
      r_in_valid = 1'b0;
      r_in_a = $urandom;
      r_in_b = $urandom;
      n = 0;
      @(negedge clk);
      while (!r_out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("r_latency", 64'(cyc - e.acc), 64'(e.lat));
      chk("r_out_q", {32'd0, r_out_q}, {32'd0, e.q});
      chk("r_out_tag", {61'd0, r_out_tag}, {61'd0, e.tag});
      chk("r_flags", {62'd0, r_out_dz, r_out_ovf}, {62'd0, e.dz, e.ovf});
    end
    r_done = 1'b1;
  end

  initial begin : main_seq
    exp_t m;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    m = model(32'h00010000, 32'h00020000, 3'd5, 1'b0);
    chk("model_1_div_2", {32'd0, m.q}, 64'h00008000);
    m = model(32'hFFFD0000, 32'h00020000, 3'd0, 1'b0);
    chk("model_m3_div_2", {32'd0, m.q}, 64'hFFFE8000);
    m = model(32'h00020000, 32'h00030000, 3'd0, 1'b0);
    chk("model_2_div_3_trunc", {32'd0, m.q}, 64'h0000AAAA);
    m = model(32'h00020000, 32'h00030000, 3'd0, 1'b1);
    chk("model_2_div_3_round", {32'd0, m.q}, 64'h0000AAAB);
    m = model(32'h80000000, 32'hFFFF0000, 3'd0, 1'b0);
    chk("model_min_div_m1", {31'd0, m.ovf, m.q}, 64'h17FFFFFFF);
    m = model(32'h80000000, 32'h00010000, 3'd0, 1'b0);
    chk("model_min_div_1", {31'd0, m.ovf, m.q}, 64'h080000000);

    do_div(32'h00010000, 32'h00020000, 3'd5);
    drain();
    do_div(32'hFFFD0000, 32'h00020000, 3'd1);
    do_div(32'h00020000, 32'h00030000, 3'd2);
    do_div(32'h00050000, 32'h00000000, 3'd3);
    do_div(32'hFFFB0000, 32'h00000000, 3'd4);
    do_div(32'h00000000, 32'h00000000, 3'd6);
    do_div(32'h40000000, 32'h00000100, 3'd7);
    do_div(32'h80000000, 32'hFFFF0000, 3'd0);
    do_div(32'h80000000, 32'h00010000, 3'd1);
    do_div(32'h00000000, 32'hFFFF0000, 3'd2);
    drain();

    @(posedge clk);
    #1;
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_after_clr", {62'd0, sticky_dz, sticky_ovf}, 64'd0);

    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      do_div(rnd_op(), rnd_op(), 3'($urandom));
    end
    drain();

    rdy_mode = 2;
    repeat (2) @(posedge clk);
    do_div(32'h00070000, 32'h00020000, 3'd6);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      in_tag = 3'($urandom);
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (60) @(negedge clk);

    do_div(32'h00030000, 32'h00000000, 3'd1);
    drain();
    do_div(32'h12345678, 32'h00012345, 3'd2);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    do_div(32'hFFFD0000, 32'h00020000, 3'd3);
    drain();

    n = 0;
    while (!r_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!r_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL round_instance_timeout: got unfinished required done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
